// File: rtl/id_ex_skid_reg_if.sv
// rtl/id_ex_skid_reg_if.sv - decode/execute handshake bundle for the ID/EX skid register
interface id_ex_skid_reg_if #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 8,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 6,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_dst;
  logic               alu_src;
  logic               branch;
  logic               mem_write;
  logic               mem_read;
  logic               reg_write;
  logic               mem_to_reg;
  logic [PC_W-1:0]    pc_next;
  logic [DATA_W-1:0]  data1;
  logic [DATA_W-1:0]  data2;
  logic [DATA_W-1:0]  sign_extend;
  logic [REG_W-1:0]   reg1;
  logic [REG_W-1:0]   reg2;

  logic               out_valid;
  logic               out_ready;
  logic [ALUOP_W-1:0] alu_op_reg;
  logic               reg_dst_reg;
  logic               alu_src_reg;
  logic               branch_reg;
  logic               mem_write_reg;
  logic               mem_read_reg;
  logic               reg_write_reg;
  logic               mem_to_reg_reg;
  logic [PC_W-1:0]    pc_next_reg;
  logic [DATA_W-1:0]  data1_reg;
  logic [DATA_W-1:0]  data2_reg;
  logic [DATA_W-1:0]  sign_extend_reg;
  logic [REG_W-1:0]   reg1_reg;
  logic [REG_W-1:0]   reg2_reg;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output in_valid, flush, alu_op, reg_dst, alu_src, branch, mem_write, mem_read,
           reg_write, mem_to_reg, pc_next, data1, data2, sign_extend, reg1, reg2, out_ready,
    input  in_ready, out_valid, alu_op_reg, reg_dst_reg, alu_src_reg, branch_reg,
           mem_write_reg, mem_read_reg, reg_write_reg, mem_to_reg_reg, pc_next_reg,
           data1_reg, data2_reg, sign_extend_reg, reg1_reg, reg2_reg, bubble_cnt
  );

  modport slave (
    input  in_valid, flush, alu_op, reg_dst, alu_src, branch, mem_write, mem_read,
           reg_write, mem_to_reg, pc_next, data1, data2, sign_extend, reg1, reg2, out_ready,
    output in_ready, out_valid, alu_op_reg, reg_dst_reg, alu_src_reg, branch_reg,
           mem_write_reg, mem_read_reg, reg_write_reg, mem_to_reg_reg, pc_next_reg,
           data1_reg, data2_reg, sign_extend_reg, reg1_reg, reg2_reg, bubble_cnt
  );
endinterface

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with one-entry skid buffer, flush and bubble counter
module id_ex_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 8,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  id_ex_skid_reg_if.slave bus_io
);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_dst;
    logic               alu_src;
    logic               branch;
    logic               mem_write;
    logic               mem_read;
    logic               reg_write;
    logic               mem_to_reg;
    logic [PC_W-1:0]    pc_next;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [DATA_W-1:0]  sign_extend;
    logic [REG_W-1:0]   reg1;
    logic [REG_W-1:0]   reg2;
  } fields_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fields_t          main_q, main_d;
  fields_t          skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  fields_t in_fields;
  logic    acc;
  logic    main_free;

  assign in_fields = '{
    alu_op:      bus_io.alu_op,
    reg_dst:     bus_io.reg_dst,
    alu_src:     bus_io.alu_src,
    branch:      bus_io.branch,
    mem_write:   bus_io.mem_write,
    mem_read:    bus_io.mem_read,
    reg_write:   bus_io.reg_write,
    mem_to_reg:  bus_io.mem_to_reg,
    pc_next:     bus_io.pc_next,
    data1:       bus_io.data1,
    data2:       bus_io.data2,
    sign_extend: bus_io.sign_extend,
    reg1:        bus_io.reg1,
    reg2:        bus_io.reg2
  };

  // in_ready comes straight from a flop so execute stalls never reach decode combinationally
  assign acc       = bus_io.in_valid & ~skid_valid_q;
  assign main_free = ~out_valid_q | bus_io.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    bubble_d     = (!out_valid_q && bubble_q != CNT_MAX) ? bubble_q + CNT_ONE : bubble_q;

    if (bus_io.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_d      = in_fields;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_d       = in_fields;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      bubble_q     <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      bubble_q     <= bubble_d;
    end
  end

  assign bus_io.in_ready   = ~skid_valid_q;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.bubble_cnt = bubble_q;

  // Bubbles must never carry side-effecting control into execute
  assign bus_io.alu_op_reg     = out_valid_q ? main_q.alu_op : '0;
  assign bus_io.reg_dst_reg    = main_q.reg_dst    & out_valid_q;
  assign bus_io.alu_src_reg    = main_q.alu_src    & out_valid_q;
  assign bus_io.branch_reg     = main_q.branch     & out_valid_q;
  assign bus_io.mem_write_reg  = main_q.mem_write  & out_valid_q;
  assign bus_io.mem_read_reg   = main_q.mem_read   & out_valid_q;
  assign bus_io.reg_write_reg  = main_q.reg_write  & out_valid_q;
  assign bus_io.mem_to_reg_reg = main_q.mem_to_reg & out_valid_q;

  assign bus_io.pc_next_reg     = main_q.pc_next;
  assign bus_io.data1_reg       = main_q.data1;
  assign bus_io.data2_reg       = main_q.data2;
  assign bus_io.sign_extend_reg = main_q.sign_extend;
  assign bus_io.reg1_reg        = main_q.reg1;
  assign bus_io.reg2_reg        = main_q.reg2;

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer, flush and a bubble counter. It sits between decode and execute, replaces the free-running ID/EX latch, and lets execute stall without losing a decoded instruction. It lets decode squash a wrong-path instruction on a taken branch, and it guarantees that bubbles carry no side-effecting control bits.

## Interface
- DATA_W, 32, width of data1/data2/sign_extend
- PC_W, 8, width of pc_next
- REG_W, 5, register-index width (reg1/reg2)
- ALUOP_W, 6, alu_op width
- CNT_W, 16, bubble counter width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block can accept this cycle
- flush  in  1  squash all held and incoming instructions
- alu_op, reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg  in  ALUOP_W/1×7  decoded control
- pc_next, data1, data2, sign_extend, reg1, reg2  in  PC_W/DATA_W×3/REG_W×2  decoded data
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute consumes this cycle
- *_reg outputs (one per input field, same widths)  out  registered fields
- bubble_cnt  out  CNT_W  cycles with out_valid=0 since reset

## Operation
- Storage: main entry (drives outputs) + skid entry, each holding the full field set plus its own valid bit (out_valid, skid_valid).
- in_ready = !skid_valid; it is a register output with no combinational path from out_ready.
- acc = in_valid & in_ready; main_free = !out_valid | out_ready.
- The following priority applies per rising edge:
  - reset: out_valid=0, skid_valid=0, all stored fields=0, bubble_cnt=0.
  - flush: out_valid=0, skid_valid=0. An instruction accepted the same cycle is discarded. Data fields are unchanged.
  - main_free & skid_valid: main <= skid, out_valid=1, skid_valid=0.
  - main_free & !skid_valid & acc: main <= inputs, out_valid=1.
  - main_free & !skid_valid & !acc: out_valid=0.
  - !main_free & acc: skid <= inputs, skid_valid=1. Main holds.
  - !main_free & !acc: all held.
- Control gating: branch_reg, mem_write_reg, mem_read_reg, reg_write_reg, mem_to_reg_reg, reg_dst_reg and alu_src_reg equal the stored value AND out_valid. alu_op_reg is 0 when out_valid=0. Data outputs show the last stored value regardless of valid.
- Ordering is strictly FIFO: an instruction is never duplicated or dropped, except by flush.
- bubble_cnt increments on each edge where out_valid=0, not in reset. It saturates at all-ones with no wrap.

## Timing
- Latency: input to output is 1 cycle when the main entry is free. It is 2 cycles when the instruction goes through the skid entry.
- Throughput: 1 instruction/cycle while out_ready=1.
- Backpressure: the first stalled cycle absorbs one more instruction into the skid entry. in_ready drops on the next cycle.
- When out_ready rises with skid_valid=1, the skid entry moves to main and in_ready returns to 1 on the following cycle.
- A flush in cycle N gives out_valid=0 and in_ready=1 in cycle N+1. A new acc is possible in N+1.
- flush and reset dominate every simultaneous handshake.
- A reset held across cycles keeps every output at 0 and in_ready=1.

## Test plan
- Streaming: reset, then out_ready=1 and in_valid=1 for 4 cycles with data1=0x11,0x22,0x33,0x44 -> data1_reg shows 0x11..0x44 one cycle later, out_valid=1 continuously, in_ready never drops.
- Stall: with A in main, drop out_ready while B is offered -> B goes to skid, in_ready=0 next cycle, A held. Raise out_ready -> A consumed, B on outputs next cycle, in_ready=1, no loss or duplication.
- Flush with both entries full, C offered the same cycle -> out_valid=0 and in_ready=1 next cycle. C, A and B are never presented. reg_write_reg and mem_write_reg are 0.
- Bubble gating: an instruction with mem_write=1 and reg_write=1 is consumed, then in_valid=0 -> the next cycle shows out_valid=0, mem_write_reg=0, reg_write_reg=0, alu_op_reg=0.
- Counter: CNT_W=3, idle for 10 cycles after reset -> bubble_cnt reads 1..7 then stays at 7. Assert reset -> bubble_cnt=0 next cycle.
- Mid-stall reset: both entries full, out_ready=0, reset asserted for 1 cycle -> next cycle all outputs 0, out_valid=0, in_ready=1.
